// File: rtl/cr_had_dbg_req_ctrl.sv
// HAD debug-request handshake: enters/leaves core debug mode on halt, breakpoint or trace.
// Optional 8-bit trace step counter under macro CR_HAD_TRACE_CNT_EN.
module cr_had_dbg_req_ctrl (
  input  logic       cpuclk,
  input  logic       cpurst,
  input  logic       trace_ctrl_req,
  input  logic       regs_haltreq,
  input  logic       bkpt_req,
  input  logic       regs_exit_dbg,
  input  logic       iu_yy_xx_dbgon,
  input  logic       regs_trace_cnt_sel,
  input  logic [7:0] regs_xx_wdata,
  output logic       had_core_dbg_mode_req,
  output logic       had_core_exit_dbg,
  output logic [2:0] had_regs_dbg_cause,
  output logic [7:0] had_regs_trace_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, DEBUG, EXIT} state_e;

  localparam logic [2:0] CAUSE_NONE  = 3'b000;
  localparam logic [2:0] CAUSE_HALT  = 3'b001;
  localparam logic [2:0] CAUSE_BKPT  = 3'b010;
  localparam logic [2:0] CAUSE_TRACE = 3'b100;

  state_e     state_q;
  logic       req_q;
  logic       exit_q;
  logic [2:0] cause_q;
  logic       trace_go;

`ifdef CR_HAD_TRACE_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Load beats decrement; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (regs_trace_cnt_sel)
      cnt_d = regs_xx_wdata;
    else if (trace_ctrl_req && (cnt_q != 8'd0))
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign trace_go           = trace_ctrl_req & (cnt_q == 8'd0);
  assign had_regs_trace_cnt = cnt_q;
`else
  logic unused_cnt_ok;
  assign unused_cnt_ok      = ^{regs_trace_cnt_sel, regs_xx_wdata};
  assign trace_go           = trace_ctrl_req;
  assign had_regs_trace_cnt = 8'd0;
`endif

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      exit_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          // Core already in debug by other means: follow it without a request.
          if (iu_yy_xx_dbgon) begin
            state_q <= DEBUG;
            cause_q <= CAUSE_NONE;
          end else if (regs_haltreq | bkpt_req | trace_go) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            cause_q <= regs_haltreq ? CAUSE_HALT :
                       bkpt_req     ? CAUSE_BKPT : CAUSE_TRACE;
          end
        end
        REQ: begin
          if (iu_yy_xx_dbgon) begin
            state_q <= DEBUG;
            req_q   <= 1'b0;
          end
        end
        DEBUG: begin
          if (regs_exit_dbg) begin
            state_q <= EXIT;
            exit_q  <= 1'b1;
          end else if (!iu_yy_xx_dbgon) begin
            state_q <= IDLE;
          end
        end
        EXIT: begin
          if (!iu_yy_xx_dbgon) begin
            state_q <= IDLE;
            exit_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          exit_q  <= 1'b0;
        end
      endcase
    end
  end

  assign had_core_dbg_mode_req = req_q;
  assign had_core_exit_dbg     = exit_q;
  assign had_regs_dbg_cause    = cause_q;

endmodule

// File: tb/tb_cr_had_dbg_req_ctrl.sv
// Directed bench for cr_had_dbg_req_ctrl; counter checks follow CR_HAD_TRACE_CNT_EN.
module tb_cr_had_dbg_req_ctrl;

  logic       cpuclk = 1'b0;
  logic       cpurst, trace_ctrl_req, regs_haltreq, bkpt_req, regs_exit_dbg;
  logic       iu_yy_xx_dbgon, regs_trace_cnt_sel;
  logic [7:0] regs_xx_wdata;
  logic       had_core_dbg_mode_req, had_core_exit_dbg;
  logic [2:0] had_regs_dbg_cause;
  logic [7:0] had_regs_trace_cnt;

  int checks   = 0;
  int failures = 0;
  logic [12:0] obs, exp_v;

  assign obs = {had_core_dbg_mode_req, had_core_exit_dbg, had_regs_dbg_cause, had_regs_trace_cnt};

  always #5 cpuclk = ~cpuclk;

  cr_had_dbg_req_ctrl dut (
    .cpuclk               (cpuclk),
    .cpurst               (cpurst),
    .trace_ctrl_req       (trace_ctrl_req),
    .regs_haltreq         (regs_haltreq),
    .bkpt_req             (bkpt_req),
    .regs_exit_dbg        (regs_exit_dbg),
    .iu_yy_xx_dbgon       (iu_yy_xx_dbgon),
    .regs_trace_cnt_sel   (regs_trace_cnt_sel),
    .regs_xx_wdata        (regs_xx_wdata),
    .had_core_dbg_mode_req(had_core_dbg_mode_req),
    .had_core_exit_dbg    (had_core_exit_dbg),
    .had_regs_dbg_cause   (had_regs_dbg_cause),
    .had_regs_trace_cnt   (had_regs_trace_cnt)
  );

  // Request and exit must never overlap.
  always @(negedge cpuclk) begin
    checks++;
    if (had_core_dbg_mode_req && had_core_exit_dbg) begin
      failures++;
      $display("FAIL mutex req=%b exit=%b required not both 1", had_core_dbg_mode_req, had_core_exit_dbg);
    end
  end

  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask

  // obs layout: {dbg_mode_req, exit_dbg, cause[2:0], trace_cnt[7:0]}
  task automatic test_reset();
    cpurst = 1'b1; regs_haltreq = 1'b1;
    tick(); tick();
    exp_v = 13'b0_0_000_00000000; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset obs=%b exp=%b", obs, exp_v); end
    cpurst = 1'b0; regs_haltreq = 1'b0;
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL idle_after_reset obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_halt();
    regs_haltreq = 1'b1;
    tick();
    exp_v = {1'b1, 1'b0, 3'b001, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL halt_req obs=%b exp=%b", obs, exp_v); end
    regs_haltreq = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL halt_req_hold obs=%b exp=%b", obs, exp_v); end
    iu_yy_xx_dbgon = 1'b1;
    tick();
    exp_v = {1'b0, 1'b0, 3'b001, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL halt_debug obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_exit();
    regs_exit_dbg = 1'b1;
    tick();
    regs_exit_dbg = 1'b0;
    exp_v = {1'b0, 1'b1, 3'b001, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exit_set obs=%b exp=%b", obs, exp_v); end
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exit_hold obs=%b exp=%b", obs, exp_v); end
    iu_yy_xx_dbgon = 1'b0;
    tick();
    exp_v = {1'b0, 1'b0, 3'b001, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exit_done obs=%b exp=%b", obs, exp_v); end
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exit_idle obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_priority();
    bkpt_req = 1'b1; trace_ctrl_req = 1'b1;
    tick();
    bkpt_req = 1'b0; trace_ctrl_req = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b010, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL prio_bkpt obs=%b exp=%b", obs, exp_v); end
    iu_yy_xx_dbgon = 1'b1;
    tick();
    exp_v = {1'b0, 1'b0, 3'b010, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL prio_debug obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_ignore();
    bkpt_req = 1'b1; regs_haltreq = 1'b1; trace_ctrl_req = 1'b1;
    tick();
    bkpt_req = 1'b0; regs_haltreq = 1'b0; trace_ctrl_req = 1'b0;
    exp_v = {1'b0, 1'b0, 3'b010, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ignore_in_debug obs=%b exp=%b", obs, exp_v); end
    regs_exit_dbg = 1'b1;
    tick();
    regs_exit_dbg = 1'b0;
    iu_yy_xx_dbgon = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ignore_no_queue obs=%b exp=%b", obs, exp_v); end
    regs_exit_dbg = 1'b1;
    tick();
    regs_exit_dbg = 1'b0;
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL exit_in_idle obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_dbgon_paths();
    trace_ctrl_req = 1'b1;
    tick();
    trace_ctrl_req = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b100, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL trace_entry obs=%b exp=%b", obs, exp_v); end
    iu_yy_xx_dbgon = 1'b1;
    tick();
    iu_yy_xx_dbgon = 1'b0;
    tick();
    exp_v = {1'b0, 1'b0, 3'b100, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL dbgon_drop obs=%b exp=%b", obs, exp_v); end
    iu_yy_xx_dbgon = 1'b1;
    tick();
    exp_v = {1'b0, 1'b0, 3'b000, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ext_debug_cause obs=%b exp=%b", obs, exp_v); end
    iu_yy_xx_dbgon = 1'b0;
    tick();
    regs_haltreq = 1'b1;
    tick();
    regs_haltreq = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b001, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL back_in_idle obs=%b exp=%b", obs, exp_v); end
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    exp_v = 13'd0; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_in_req obs=%b exp=%b", obs, exp_v); end
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL no_pending_after_reset obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    regs_haltreq = 1'b1;
    tick();
    regs_haltreq = 1'b0; iu_yy_xx_dbgon = 1'b1;
    tick();
    regs_exit_dbg = 1'b1;
    tick();
    regs_exit_dbg = 1'b0;
    exp_v = {1'b0, 1'b1, 3'b001, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL b2b_exit obs=%b exp=%b", obs, exp_v); end
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0; iu_yy_xx_dbgon = 1'b0;
    exp_v = 13'd0; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_in_exit obs=%b exp=%b", obs, exp_v); end
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL idle_after_exit_reset obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_trace_cnt();
`ifdef CR_HAD_TRACE_CNT_EN
    regs_trace_cnt_sel = 1'b1; regs_xx_wdata = 8'd3;
    tick();
    regs_trace_cnt_sel = 1'b0;
    exp_v = {1'b0, 1'b0, 3'b000, 8'd3}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cnt_load obs=%b exp=%b", obs, exp_v); end
    trace_ctrl_req = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      tick();
      exp_v = {1'b0, 1'b0, 3'b000, 8'(i)}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL cnt_dec%0d obs=%b exp=%b", i, obs, exp_v); end
    end
    tick();
    trace_ctrl_req = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b100, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cnt_trace_entry obs=%b exp=%b", obs, exp_v); end
    regs_trace_cnt_sel = 1'b1; regs_xx_wdata = 8'd5; trace_ctrl_req = 1'b1;
    tick();
    regs_trace_cnt_sel = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b100, 8'd5}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cnt_load_wins obs=%b exp=%b", obs, exp_v); end
    tick();
    trace_ctrl_req = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b100, 8'd4}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cnt_dec_in_req obs=%b exp=%b", obs, exp_v); end
`else
    regs_trace_cnt_sel = 1'b1; regs_xx_wdata = 8'd5; trace_ctrl_req = 1'b1;
    tick();
    regs_trace_cnt_sel = 1'b0; trace_ctrl_req = 1'b0;
    exp_v = {1'b1, 1'b0, 3'b100, 8'd0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nocnt_trace obs=%b exp=%b", obs, exp_v); end
`endif
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    exp_v = 13'd0; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL cnt_reset obs=%b exp=%b", obs, exp_v); end
  endtask

  initial begin
    cpurst = 1'b1; trace_ctrl_req = 1'b0; regs_haltreq = 1'b0; bkpt_req = 1'b0;
    regs_exit_dbg = 1'b0; iu_yy_xx_dbgon = 1'b0; regs_trace_cnt_sel = 1'b0;
    regs_xx_wdata = 8'd0;
    test_reset();
    test_halt();
    test_exit();
    test_priority();
    test_ignore();
    test_dbgon_paths();
    test_back_to_back();
    test_trace_cnt();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
